// File: rtl/tag_reorder_collector_if.sv
// Bus between parallel producers, the reorder collector and the in-order consumer.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits for ready, and payload stays stable while valid is high and ready low.
interface tag_reorder_collector_if #(
  parameter int SIZE = 16,
  parameter int K    = 8,
  parameter int NCH  = 4
);
  localparam int TW = $clog2(SIZE);

  logic [NCH-1:0]    in_valid;
  logic [NCH*TW-1:0] in_tag;
  logic [NCH*K-1:0]  in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [TW-1:0]     out_tag;
  logic [K-1:0]      out_data;
  logic              out_ready;
  logic              frame_done;

  modport master (
    output in_valid, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_tag, out_data, frame_done
  );

  modport slave (
    input  in_valid, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_tag, out_data, frame_done
  );
endinterface

// File: rtl/tag_reorder_collector.sv
// Buffers tagged results from NCH producers in tag-indexed slots and emits them
// strictly in tag order 0..SIZE-1 (wrapping) through a registered output stage.
module tag_reorder_collector #(
  parameter int SIZE = 16,
  parameter int K    = 8,
  parameter int NCH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  tag_reorder_collector_if.slave bus
);
  localparam int TW = $clog2(SIZE);

  logic [SIZE-1:0] slot_full_q, slot_full_d;
  logic [K-1:0]    slot_data_q [SIZE];
  logic [K-1:0]    slot_data_d [SIZE];
  logic [TW-1:0]   exp_ptr_q, exp_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [TW-1:0]   out_tag_q, out_tag_d;
  logic [K-1:0]    out_data_q, out_data_d;
  logic            frame_done_q, frame_done_d;
  logic [NCH-1:0]  in_ready_c;
  logic            out_free;

  // Lowest channel wins a same-tag collision, whether or not it can itself be accepted.
  always_comb begin
    in_ready_c = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready_c[i] = !slot_full_q[bus.in_tag[i*TW +: TW]] && !rst && !clear;
      for (int j = 0; j < i; j++) begin
        if (bus.in_valid[j] && (bus.in_tag[j*TW +: TW] == bus.in_tag[i*TW +: TW])) begin
          in_ready_c[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    slot_full_d  = slot_full_q;
    slot_data_d  = slot_data_q;
    exp_ptr_d    = exp_ptr_q;
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_data_d   = out_data_q;
    out_free     = !out_valid_q || bus.out_ready;
    frame_done_d = out_valid_q && bus.out_ready && (out_tag_q == TW'(SIZE - 1));

    // Emit reads the pre-edge slot contents, so a slot written this cycle is never bypassed.
    if (out_free) begin
      if (slot_full_q[exp_ptr_q]) begin
        out_valid_d            = 1'b1;
        out_tag_d              = exp_ptr_q;
        out_data_d             = slot_data_q[exp_ptr_q];
        slot_full_d[exp_ptr_q] = 1'b0;
        exp_ptr_d              = exp_ptr_q + TW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A write only targets an empty slot and emit only a full one, so they never collide.
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_valid[i] && in_ready_c[i]) begin
        slot_full_d[bus.in_tag[i*TW +: TW]] = 1'b1;
        slot_data_d[bus.in_tag[i*TW +: TW]] = bus.in_data[i*K +: K];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      slot_full_q  <= '0;
      exp_ptr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_tag_q    <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_full_q  <= slot_full_d;
      exp_ptr_q    <= exp_ptr_d;
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Payload storage is qualified by slot_full, so it carries no reset.
  always_ff @(posedge clk) begin
    slot_data_q <= slot_data_d;
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_tag_reorder_collector.sv
// Directed bench for tag_reorder_collector: drivers feed tagged results, a monitor
// pops expected {tag,data} pairs whenever the output handshakes.
module tb_tag_reorder_collector;
  localparam int SIZE = 16;
  localparam int K    = 8;
  localparam int NCH  = 4;
  localparam int TW   = 4;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  tag_reorder_collector_if #(.SIZE(SIZE), .K(K), .NCH(NCH)) bus ();

  tag_reorder_collector #(.SIZE(SIZE), .K(K), .NCH(NCH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [TW+K-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int fd_count = 0;
  int fd0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    logic [TW+K-1:0] e;
    if (!rst) begin
      if (bus.frame_done) fd_count++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h/%0h expected=none", bus.out_tag, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_tag_data", {bus.out_tag, bus.out_data}, e);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int tag, int data);
    exp_q.push_back({tag[TW-1:0], data[K-1:0]});
  endtask

  task automatic set_ch(int ch, int tag, int data);
    bus.in_valid[ch]        = 1'b1;
    bus.in_tag[ch*TW +: TW] = tag[TW-1:0];
    bus.in_data[ch*K +: K]  = data[K-1:0];
  endtask

  // Holds every raised channel until it is accepted; optionally checks the first-cycle ready mask.
  task automatic run_accept(logic [NCH-1:0] mask, logic [NCH-1:0] exp_rdy);
    int n = 0;
    logic [NCH-1:0] acc;
    while (bus.in_valid != '0 && n < 60) begin
      @(negedge clk);
      if (n == 0 && mask != '0) check("in_ready_first", bus.in_ready & mask, exp_rdy);
      acc = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #1;
      bus.in_valid = bus.in_valid & ~acc;
      n++;
    end
    if (bus.in_valid != '0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0h expected=0", bus.in_valid);
      bus.in_valid = '0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    check("in_ready_during_clear", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = '0;
    bus.in_tag    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    step(2);
    @(negedge clk);
    check("in_ready_during_rst", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_frame_done", bus.frame_done, 0);
    @(posedge clk);
    #1;

    // 1: in-order single channel, one full frame
    for (int t = 0; t < SIZE; t++) push_exp(t, 8'h10 + t);
    fd0 = fd_count;
    for (int t = 0; t < SIZE; t++) begin
      set_ch(0, t, 8'h10 + t);
      run_accept('0, '0);
    end
    wait_drain();
    step(2);
    check("t1_frame_done_count", fd_count - fd0, 1);

    // 2: four distinct out-of-order tags in one cycle
    push_exp(0, 8'hA0); push_exp(1, 8'hA1); push_exp(2, 8'hA2); push_exp(3, 8'hA3);
    set_ch(0, 2, 8'hA2); set_ch(1, 0, 8'hA0); set_ch(2, 3, 8'hA3); set_ch(3, 1, 8'hA1);
    run_accept(4'hF, 4'hF);
    wait_drain();

    // 3: same-tag collision; the loser lands in next frame's slot 5
    push_exp(4, 8'h44);
    set_ch(0, 4, 8'h44);
    run_accept('0, '0);
    push_exp(5, 8'h55);
    set_ch(0, 5, 8'h55);
    set_ch(2, 5, 8'h77);
    run_accept(4'b0101, 4'b0001);
    wait_drain();
    step(4);
    fd0 = fd_count;
    for (int t = 6; t < SIZE; t++) push_exp(t, 8'h60 + t);
    for (int t = 0; t < 5; t++) push_exp(t, 8'h60 + t);
    push_exp(5, 8'h77);
    for (int t = 6; t < SIZE + 5; t++) begin
      set_ch(1, t % SIZE, 8'h60 + (t % SIZE));
      run_accept('0, '0);
    end
    wait_drain();
    step(2);
    check("t3_frame_done_count", fd_count - fd0, 1);
    pulse_clear();

    // 4: backpressure holds the output register
    bus.out_ready = 1'b0;
    for (int t = 0; t < 4; t++) push_exp(t, 8'hB0 + t);
    for (int t = 0; t < 4; t++) set_ch(t, t, 8'hB0 + t);
    run_accept(4'hF, 4'hF);
    step(1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_tag", bus.out_tag, 0);
      check("bp_out_data", bus.out_data, 8'hB0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_drain();
    pulse_clear();

    // 5: two full frames, first filled in reverse (buffer goes full), second forward
    fd0 = fd_count;
    for (int t = 0; t < SIZE; t++) push_exp(t, 8'hC0 + t);
    for (int t = 0; t < SIZE; t++) push_exp(t, 8'hD0 + t);
    for (int t = SIZE - 1; t >= 0; t--) begin
      set_ch(1, t, 8'hC0 + t);
      run_accept('0, '0);
    end
    @(negedge clk);
    check("full_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    for (int t = 0; t < SIZE; t++) begin
      set_ch(3, t, 8'hD0 + t);
      run_accept('0, '0);
    end
    wait_drain();
    step(2);
    check("t5_frame_done_count", fd_count - fd0, 2);
    pulse_clear();

    // 6: reset mid-operation discards buffered and presented results
    push_exp(0, 8'hE0); push_exp(1, 8'hE1);
    set_ch(0, 0, 8'hE0); set_ch(1, 1, 8'hE1);
    run_accept('0, '0);
    wait_drain();
    bus.out_ready = 1'b0;
    for (int t = 0; t < 4; t++) set_ch(t, t + 2, 8'hE2 + t);
    run_accept('0, '0);
    set_ch(0, 6, 8'hE6); set_ch(1, 7, 8'hE7);
    run_accept('0, '0);
    step(3);
    bus.in_tag = {NCH{4'd8}};
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_mid_rst", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_tag", bus.out_tag, 0);
    check("mid_rst_in_ready", bus.in_ready, 4'hF);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    step(5);
    check("no_out_before_tag0", bus.out_valid, 0);
    push_exp(0, 8'h99);
    set_ch(0, 0, 8'h99);
    run_accept('0, '0);
    wait_drain();
    step(5);
    check("old_tags_discarded", bus.out_valid, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tag_reorder_collector.md
Name: tag_reorder_collector

Overview:
- Collects tagged results from NCH parallel producers. Each result carries a $clog2(SIZE)-bit tag and K-bit data.
- Stores each result in a slot indexed by its tag, then emits the results strictly in tag order 0,1,…,SIZE-1, wrapping back to 0.
- Generalises the combinational tag-match selector: arbitrary channel count, buffering, valid/ready handshakes, and in-order draining with backpressure.
- Sits between the parallel compute lanes and the sequential result consumer.

Parameters:
- SIZE, 16, number of tags and buffer slots; must be a power of two and ≥2.
- K, 8, data width.
- NCH, 4, number of producer channels; ≥1.
- TW (localparam), $clog2(SIZE), tag width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of buffer and pointer; same effect as rst.
- in_valid  in  NCH  per-channel result valid.
- in_tag  in  NCH*TW  channel i tag at [i*TW +: TW].
- in_data  in  NCH*K  channel i data at [i*K +: K].
- in_ready  out  NCH  per-channel accept; combinational.
- out_valid  out  1  output holds the next in-order result.
- out_tag  out  TW  tag of the current output.
- out_data  out  K  data of the current output.
- out_ready  in  1  consumer accept.
- frame_done  out  1  one-cycle pulse when tag SIZE-1 is accepted at the output.

Behaviour:
- State:
  - slot_data[SIZE] of K bits, slot_full[SIZE] of 1 bit.
  - exp_ptr of TW bits: next tag to emit.
  - Output registers out_valid, out_tag, out_data.
- Reset and clear:
  - Both are synchronous; rst has priority over clear.
  - All slot_full=0, exp_ptr=0, out_valid=0, out_tag=0, out_data=0, frame_done=0.
  - slot_data need not be reset.
  - in_ready=0 while rst or clear is high.
  - Reset mid-operation discards all buffered and presented results; no output is produced from pre-reset data.
- in_ready[i] is 1 iff:
  - slot_full[in_tag_i]=0, and
  - no lower-index channel j<i has in_valid[j]=1 with in_tag_j==in_tag_i.
  - in_ready does not depend on in_valid[i].
- Write: on each edge, every channel with in_valid & in_ready sets slot_full[tag]=1 and slot_data[tag]=data.
  - Distinct tags from multiple channels are all written in the same cycle.
  - On a same-tag collision the lowest channel wins; higher channels hold (valid stays high, data stable) until their slot frees.
- Emit: when the output register is free (!out_valid | out_ready) and slot_full[exp_ptr]=1, on the edge:
  - out_valid=1, out_tag=exp_ptr, out_data=slot_data[exp_ptr];
  - slot_full[exp_ptr]=0;
  - exp_ptr=exp_ptr+1, modulo SIZE (wraps SIZE-1→0).
- Output register free but slot_full[exp_ptr]=0: out_valid clears if out_ready was high, else it holds.
- Latency: a result written at edge t to the exp_ptr slot appears with out_valid=1 after edge t+1. There is no same-cycle bypass. Sustained throughput is 1 result/cycle when in order.
- Freed-slot reuse: a slot freed at edge t shows in_ready=1 in the cycle after edge t. It accepts the next-frame result for that tag, which then waits until exp_ptr wraps around to it.
- Backpressure: while out_valid=1 and out_ready=0, out_tag/out_data/exp_ptr are held stable. Writes to other slots continue.
- frame_done=1 for exactly one cycle, the cycle after an edge where out_valid & out_ready & out_tag==SIZE-1.
- Buffer full (all slot_full=1): all in_ready=0; draining resumes normally.
- A missing tag stalls the output indefinitely. This is legal; there is no timeout.

Test Plan:
1. NCH=4, SIZE=16, K=8. Channel 0 sends tags 0..15 in order, data=tag+0x10, out_ready=1 → outputs 0x10..0x1F in order, one per cycle after a 2-cycle start; frame_done pulses once after tag 15.
2. Same cycle: ch0 tag2/0xA2, ch1 tag0/0xA0, ch2 tag3/0xA3, ch3 tag1/0xA1 → all in_ready=1; outputs in order tag0 0xA0, 1 0xA1, 2 0xA2, 3 0xA3 on four consecutive cycles.
3. Collision: ch0 and ch2 both tag5 (0x55 / 0x77), exp_ptr=5 →
   - ch0 accepted, in_ready[2]=0;
   - 0x55 emitted;
   - next cycle in_ready[2]=1, 0x77 stored for the next frame's tag 5 and not emitted until exp_ptr wraps.
4. Backpressure: tags 0..3 stored, out_ready=0 for 5 cycles → out_valid=1, out_tag=0, out_data stable throughout; release → tags 0,1,2,3 on consecutive cycles.
5. Wrap: fill and drain two full frames → exp_ptr wraps 15→0; second frame is emitted in order; frame_done pulses twice.
6. Reset mid-operation: tags 0..7 stored, tags 0..1 emitted, assert rst one cycle → out_valid=0, in_ready=0 during rst; after release tag 0 must be resupplied before any output; old tags 2..7 are never emitted.
